// File: rtl/alu_muldiv_seq.sv
// EX-stage integer unit: registered RV32I results, iterative radix-2 RV32M multiply/divide.
// Operations issue on in_valid/in_ready and retire on out_valid/out_ready.
module alu_muldiv_seq #(
   parameter int XLEN     = 32,
   parameter int SHW      = $clog2(XLEN),
   parameter int ENABLE_M = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_zero,
   output logic            out_illegal,
   output logic            busy
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2,  OP_SLT  = 5'd3,
      OP_SLTU = 5'd4,  OP_XOR    = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7,
      OP_OR   = 5'd8,  OP_AND    = 5'd9,  OP_MUL   = 5'd10, OP_MULH = 5'd11,
      OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU = 5'd15,
      OP_REM  = 5'd16, OP_REMU   = 5'd17
   } op_e;

   state_e          state, state_n;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc_hi, acc_lo, opnd;
   logic            neg_q;
   logic [4:0]      op_q;

   // Issue-side decode
   logic            is_base, is_m, is_div, is_signed_div, is_quot, is_illegal;
   logic            sign_a, sign_b, div_zero, div_ovf, bypass, needs_calc, accept;
   logic [XLEN-1:0] mag_a, mag_b, base_res, bypass_res, fast_res;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      base_res = '0;
      case (in_op)
         OP_ADD:  base_res = in_a + in_b;
         OP_SUB:  base_res = in_a - in_b;
         OP_SLL:  base_res = in_a << in_b[SHW-1:0];
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
         OP_XOR:  base_res = in_a ^ in_b;
         OP_SRL:  base_res = in_a >> in_b[SHW-1:0];
         OP_SRA:  base_res = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
         OP_OR:   base_res = in_a | in_b;
         OP_AND:  base_res = in_a & in_b;
         default: base_res = '0;
      endcase
   end

   always_comb begin
      is_base       = (in_op <= 5'd9);
      is_m          = (ENABLE_M != 0) && (in_op >= 5'd10) && (in_op <= 5'd17);
      is_div        = is_m && (in_op >= 5'd14);
      is_signed_div = is_m && ((in_op == OP_DIV) || (in_op == OP_REM));
      is_quot       = (in_op == OP_DIV) || (in_op == OP_DIVU);
      is_illegal    = !(is_base || is_m);

      sign_a = in_a[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_MULHSU) | is_signed_div);
      sign_b = in_b[XLEN-1] & ((in_op == OP_MULH) | is_signed_div);
      mag_a  = sign_a ? -in_a : in_a;
      mag_b  = sign_b ? -in_b : in_b;

      div_zero   = (in_b == '0);
      div_ovf    = (in_a == MIN_NEG) && (in_b == '1);
      bypass     = is_div && (div_zero || (is_signed_div && div_ovf));
      needs_calc = is_m && !bypass;

      // Architected results for divide-by-zero and signed overflow skip the iteration.
      if (div_zero) bypass_res = is_quot ? '1 : in_a;
      else          bypass_res = is_quot ? in_a : '0;

      if (is_illegal)   fast_res = '0;
      else if (is_base) fast_res = base_res;
      else              fast_res = bypass_res;
   end

   // One radix-2 step; the multiply/divide choice comes from the captured opcode
   logic            q_mul;
   logic [XLEN:0]   mul_sum, div_shift;
   logic [XLEN-1:0] div_diff, hi_n, lo_n;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] q_fix, r_fix, final_res;

   always_comb begin
      q_mul     = (op_q <= OP_MULHU);
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift[XLEN-1:0] - opnd;

      if (q_mul) begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
      end else if (div_shift >= {1'b0, opnd}) begin
         hi_n = div_diff;
         lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
         hi_n = div_shift[XLEN-1:0];
         lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end

      prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      q_fix    = neg_q ? -lo_n : lo_n;
      r_fix    = neg_q ? -hi_n : hi_n;

      case (op_q)
         OP_MUL:                      final_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             final_res = q_fix;
         default:                     final_res = r_fix;
      endcase
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = needs_calc ? CALC : DONE;
         end
         CALC: begin
            if (cnt == CNT_LAST) state_n = DONE;
         end
         DONE: begin
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) state_n = needs_calc ? CALC : DONE;
               else          state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      accept    = in_valid & in_ready;
      out_valid = (state == DONE);
      busy      = (state == CALC);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opnd        <= '0;
         neg_q       <= 1'b0;
         op_q        <= '0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_q <= in_op;
            if (needs_calc) begin
               cnt    <= '0;
               acc_hi <= '0;
               acc_lo <= (in_op <= OP_MULHU) ? mag_b : mag_a;
               opnd   <= (in_op <= OP_MULHU) ? mag_a : mag_b;
               neg_q  <= (in_op == OP_REM) ? sign_a : (sign_a ^ sign_b);
            end else begin
               out_result  <= fast_res;
               out_zero    <= (fast_res == '0);
               out_illegal <= is_illegal;
            end
         end else if (state == CALC) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            if (cnt == CNT_LAST) begin
               out_result  <= final_res;
               out_zero    <= (final_res == '0);
               out_illegal <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed vector table, handshake and reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal, busy;
   logic [4:0]  in_op;
   logic [31:0] in_a, in_b, out_result;

   logic        nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready;
   logic        nm_out_zero, nm_out_illegal, nm_busy;
   logic [4:0]  nm_in_op;
   logic [31:0] nm_in_a, nm_in_b, nm_out_result;

   always #5 clk = ~clk;

   alu_muldiv_seq #(.XLEN(32), .SHW(5), .ENABLE_M(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
      .out_illegal(out_illegal), .busy(busy)
   );

   alu_muldiv_seq #(.XLEN(32), .SHW(5), .ENABLE_M(0)) dut_nm (
      .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
      .in_op(nm_in_op), .in_a(nm_in_a), .in_b(nm_in_b), .out_valid(nm_out_valid),
      .out_ready(nm_out_ready), .out_result(nm_out_result), .out_zero(nm_out_zero),
      .out_illegal(nm_out_illegal), .busy(nm_busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: RISC-V semantics from plain wide arithmetic
   function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << b[4:0];
         5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd4:  return (a < b) ? 32'd1 : 32'd0;
         5'd5:  return a ^ b;
         5'd6:  return a >> b[4:0];
         5'd7:  return $unsigned($signed(a) >>> b[4:0]);
         5'd8:  return a | b;
         5'd9:  return a & b;
         5'd10: begin p = ua * ub;           return p[31:0];  end
         5'd11: begin p = sa * sb;           return p[63:32]; end
         5'd12: begin p = sa * longint'(ub); return p[63:32]; end
         5'd13: begin p = ua * ub;           return p[63:32]; end
         5'd14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd16: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         5'd17: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op <= 5'd9 || op >= 5'd18) return 1;
      if (op >= 5'd14 && (b == 0 || ((op == 5'd14 || op == 5'd16) &&
          a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 33;
   endfunction

   // Issue one op from IDLE (called at a negedge), measure latency, hold for stall cycles, retire.
   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill,
                         input int exp_lat, input int stall);
      int lat, nbusy;
      check({name, "/in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_op = 5'($urandom); in_a = $urandom; in_b = $urandom;
      lat = 1; nbusy = 0;
      while (!out_valid && lat <= 40) begin
         nbusy += int'(busy);
         @(negedge clk);
         lat++;
      end
      check({name, "/latency"}, 32'(lat), 32'(exp_lat));
      check({name, "/result"}, out_result, exp_res);
      check({name, "/zero"}, 32'(out_zero), 32'(exp_res == 32'd0));
      check({name, "/illegal"}, 32'(out_illegal), 32'(exp_ill));
      check({name, "/busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({name, "/hold"}, out_result, exp_res);
         check({name, "/hold_valid"}, 32'(out_valid && !in_ready), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({name, "/retired"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a, b, res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      int          lat;

      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
      nm_in_valid = 1'b0; nm_in_op = '0; nm_in_a = '0; nm_in_b = '0; nm_out_ready = 1'b0;

      #12;
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/out_result", out_result, 32'd0);
      check("reset/out_zero", 32'(out_zero), 32'd0);
      check("reset/out_illegal", 32'(out_illegal), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      vecs.push_back('{"add_wrap", 5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1});
      vecs.push_back('{"sub_zero", 5'd1,  32'd5,         32'd5,         32'h0,         1'b0, 1});
      vecs.push_back('{"sra",      5'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1});
      vecs.push_back('{"srl",      5'd6,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1});
      vecs.push_back('{"slt",      5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1});
      vecs.push_back('{"sltu",     5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1});
      vecs.push_back('{"sll_mask", 5'd2,  32'd1,         32'd35,        32'd8,         1'b0, 1});
      vecs.push_back('{"xor",      5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1});
      vecs.push_back('{"or",       5'd8,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1});
      vecs.push_back('{"and",      5'd9,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0,         1'b0, 1});
      vecs.push_back('{"mulh",     5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 33});
      vecs.push_back('{"mulhu",    5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
      vecs.push_back('{"mulhsu",   5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{"mul",      5'd10, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0, 33});
      vecs.push_back('{"div",      5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33});
      vecs.push_back('{"rem",      5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{"divu",     5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33});
      vecs.push_back('{"remu",     5'd17, 32'd100,       32'd7,         32'd2,         1'b0, 33});
      vecs.push_back('{"div0",     5'd14, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1'b0, 1});
      vecs.push_back('{"divu0",    5'd15, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1'b0, 1});
      vecs.push_back('{"rem0",     5'd16, 32'd1234,      32'd0,         32'd1234,      1'b0, 1});
      vecs.push_back('{"remu0",    5'd17, 32'd1234,      32'd0,         32'd1234,      1'b0, 1});
      vecs.push_back('{"div_ovf",  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
      vecs.push_back('{"rem_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1});
      vecs.push_back('{"ill20",    5'd20, 32'd5,         32'd6,         32'h0,         1'b1, 1});
      vecs.push_back('{"ill31",    5'd31, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b1, 1});

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                vecs[i].ill, vecs[i].lat, i % 3);

      // Backpressure, then back-to-back accept of an M op on the retiring edge
      in_valid = 1'b1; in_op = 5'd0; in_a = 32'd1; in_b = 32'd2; out_ready = 1'b0;
      @(negedge clk);
      in_op = 5'd13; in_a = 32'hFFFF_FFFF; in_b = 32'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp/valid", 32'(out_valid), 32'd1);
         check("bp/result", out_result, 32'd3);
         check("bp/in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1 check("bp/in_ready_release", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b/not_duplicated", 32'(out_valid), 32'd0);
      check("b2b/busy", 32'(busy), 32'd1);
      lat = 1;
      while (!out_valid && lat <= 40) begin @(negedge clk); lat++; end
      check("b2b/latency", 32'(lat), 32'd33);
      check("b2b/result", out_result, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("b2b/retired", 32'(out_valid), 32'd0);

      // Sustained base-op throughput with out_ready held high
      in_valid = 1'b1; in_op = 5'd0;
      for (int k = 1; k <= 4; k++) begin
         in_a = 32'(k); in_b = 32'(k);
         @(negedge clk);
         check("stream/valid", 32'(out_valid), 32'd1);
         check("stream/result", out_result, 32'(2 * k));
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream/drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a DIVU, with an ignored request while busy
      run_op("pre_rst", 5'd20, 32'd1, 32'd2, 32'd0, 1'b1, 1, 0);
      in_valid = 1'b1; in_op = 5'd15; in_a = 32'd1000; in_b = 32'd7;
      @(negedge clk);
      in_op = 5'd0; in_a = 32'd1; in_b = 32'd1;
      check("busy/in_ready", 32'(in_ready), 32'd0);
      check("busy/busy", 32'(busy), 32'd1);
      repeat (9) @(negedge clk);
      check("busy/no_capture", 32'(out_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst/out_valid", 32'(out_valid), 32'd0);
      check("arst/busy", 32'(busy), 32'd0);
      check("arst/out_result", out_result, 32'd0);
      check("arst/out_zero", 32'(out_zero), 32'd0);
      check("arst/out_illegal", 32'(out_illegal), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst/in_ready", 32'(in_ready), 32'd1);
      check("post_rst/out_valid", 32'(out_valid), 32'd0);
      check("post_rst/busy", 32'(busy), 32'd0);

      // Instance without the M extension
      for (int k = 0; k < 2; k++) begin
         nm_in_valid = 1'b1; nm_in_op = (k == 0) ? 5'd10 : 5'd0;
         nm_in_a = 32'd3; nm_in_b = 32'd4; nm_out_ready = 1'b1;
         check("nm/in_ready", 32'(nm_in_ready), 32'd1);
         @(negedge clk);
         nm_in_valid = 1'b0;
         check("nm/valid_lat1", 32'(nm_out_valid), 32'd1);
         check("nm/result", nm_out_result, (k == 0) ? 32'd0 : 32'd7);
         check("nm/zero", 32'(nm_out_zero), (k == 0) ? 32'd1 : 32'd0);
         check("nm/illegal", 32'(nm_out_illegal), (k == 0) ? 32'd1 : 32'd0);
         check("nm/busy", 32'(nm_busy), 32'd0);
         @(negedge clk);
      end

      // Randomized ops against the reference model
      for (int n = 0; n < 150; n++) begin
         rop = 5'($urandom_range(0, 19));
         ra  = pick();
         rb  = pick();
         run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, model_res(rop, ra, rb),
                rop >= 5'd18, model_lat(rop, ra, rb), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
